// File: rtl/logdrop_window_accum.sv
// Window sequencer and accumulator around the combinational logdrop window stage.
// Build option: define LOGDROP_WINDOW_ACCUM_MEAN_EN to present the window mean instead of the raw sum.
module logdrop_window_accum #(
  parameter int DATA_W = 8,
  parameter int WINLEN = 32,
  parameter int SUM_W  = DATA_W + $clog2(WINLEN)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cg,
  input  logic                      i_clear,
  input  logic                      i_x_valid,
  output logic                      o_x_ready,
  input  logic [DATA_W-1:0]         i_x,
  output logic [DATA_W-1:0]         o_x,
  output logic [$clog2(WINLEN)-1:0] o_t,
  input  logic [DATA_W-1:0]         i_y,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [SUM_W-1:0]          o_sum
);

  localparam int T_W = $clog2(WINLEN);

  // Handshakes: a transfer happens on a cycle where valid && ready are both 1
  // (and i_cg=1). Once o_valid rises, o_sum is held stable until it transfers.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] window_total;
  logic [SUM_W-1:0] load_value;
  logic             last_slot;
  logic             accept;
  logic             complete;
  logic             drain;

  assign o_x       = i_x;
  assign o_t       = t_q;
  assign o_valid   = (state_q == ST_FULL);
  assign o_sum     = sum_q;

  assign last_slot = (t_q == T_W'(WINLEN - 1));
  // Only the closing sample stalls, and only when the finished sum has nowhere to go.
  assign o_x_ready = i_cg && !i_clear && !(last_slot && o_valid && !i_ready);
  assign accept    = i_x_valid && o_x_ready;
  assign complete  = accept && last_slot;
  assign drain     = o_valid && i_ready && i_cg;

  assign window_total = acc_q + SUM_W'(i_y);

`ifdef LOGDROP_WINDOW_ACCUM_MEAN_EN
  assign load_value = window_total >> T_W;
`else
  assign load_value = window_total;
`endif

  // Window position and running sum.
  always_comb begin
    t_d   = t_q;
    acc_d = acc_q;
    if (i_cg) begin
      if (i_clear) begin
        t_d   = '0;
        acc_d = '0;
      end else if (accept) begin
        if (last_slot) begin
          t_d   = '0;
          acc_d = '0;
        end else begin
          t_d   = t_q + T_W'(1);
          acc_d = window_total;
        end
      end
    end
  end

  // Holding register next state; refill during drain keeps it FULL with no bubble.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    case (state_q)
      ST_EMPTY: begin
        if (complete) begin
          state_d = ST_FULL;
          sum_d   = load_value;
        end
      end
      ST_FULL: begin
        if (complete) begin
          state_d = ST_FULL;
          sum_d   = load_value;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      t_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: doc/logdrop_window_accum.md
Name: logdrop_window_accum

Overview:
- Sequencer and accumulator wrapped around the combinational logdrop window stage.
- Accepts a sample stream and drives the window index `o_t` plus the sample `o_x` to the window stage. Takes the windowed result back on `i_y` in the same cycle.
- Sums `i_y` over each WINLEN-sample window and presents one sum per window on a valid/ready output with a single holding register.
- Feeds downstream correlation/statistics logic.

Parameters:
- DATA_W, 8: sample width, fx-format.
- WINLEN, 32: window length; power of 2, at least 8.
- SUM_W, DATA_W+$clog2(WINLEN): accumulator and result width; cannot overflow.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  synchronous, active-low reset.
- i_cg  input  1  clock gate; state updates only when 1.
- i_clear  input  1  synchronous restart of the current window.
- i_x_valid  input  1  input sample valid.
- o_x_ready  output  1  input sample ready.
- i_x  input  DATA_W  input sample.
- o_x  output  DATA_W  sample to window stage; equals i_x, combinational.
- o_t  output  $clog2(WINLEN)  window index of the current sample; registered.
- i_y  input  DATA_W  windowed sample returned by the window stage, same cycle.
- o_valid  output  1  window sum valid.
- i_ready  input  1  downstream ready.
- o_sum  output  SUM_W  window sum; registered.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): o_t=0, accumulator=0, o_valid=0, o_sum=0. Reset overrides i_cg and i_clear. A partial window is discarded.
- Accept condition: `acc = i_x_valid && o_x_ready`.
- o_x_ready = i_cg && !i_clear && !(o_t==WINLEN-1 && o_valid && !i_ready).
  - Only the last sample of a window stalls, and only while the holding register is full and not draining.
- Output drain condition: `drain = o_valid && i_ready && i_cg`. On drain, o_valid clears unless refilled in the same cycle.
- Two states, tracked implicitly by o_valid: EMPTY (o_valid=0) and FULL (o_valid=1).
  - EMPTY → FULL on window completion.
  - FULL → EMPTY on drain without completion.
  - FULL → FULL on simultaneous drain and completion: new sum loaded, no bubble.
- Accept with o_t<WINLEN-1: accumulator += i_y zero-extended to SUM_W; o_t += 1.
- Accept with o_t==WINLEN-1 (completion): o_sum = accumulator + i_y; o_valid=1; accumulator=0; o_t wraps to 0. Latency: o_valid rises the cycle after the last accept.
- i_clear=1 with i_cg=1: accumulator=0, o_t=0, no sample accepted. The o_sum/o_valid holding register is untouched.
- i_cg=0: no state changes at all; o_x_ready=0; o_valid and o_sum hold.
- o_sum is stable while o_valid=1 && !i_ready.
- i_y is sampled only on accept; its value is ignored otherwise.

Optional Feature:
- Macro: LOGDROP_WINDOW_ACCUM_MEAN_EN.
- Defined: on completion, o_sum is loaded with (accumulator + i_y) >> $clog2(WINLEN), zero-extended to SUM_W, giving the window mean. The upper $clog2(WINLEN) bits are always 0.
- Undefined: o_sum holds the raw sum.
- Port list and timing are identical in both builds.

Test Plan (WINLEN=8, DATA_W=8, SUM_W=11; bench drives i_y directly):
- Reset with all inputs 0, then release -> o_t=0, o_valid=0, o_sum=0. o_x_ready=1 once i_cg=1.
- 8 accepts with i_y=8'hFF, i_ready=1 -> o_t steps 0..7 then wraps to 0. o_valid=1 for exactly one cycle after the 8th accept, with o_sum=11'h7F8; with the macro, o_sum=11'h0FF.
- i_ready=0; window 1 with i_y=1..8, then window 2 with i_y=2 -> after window 1, o_sum=36 held. Window 2's 8th sample sees o_x_ready=0 and o_sum stays 36. Raise i_ready -> 8th sample accepted that cycle; next cycle o_valid=1 and o_sum=16.
- 3 accepts with i_y=10, then i_clear for 1 cycle, then 8 accepts with i_y=1 -> o_t=0 after clear, o_x_ready=0 during clear, next o_sum=8.
- i_cg=0 for 5 cycles with i_x_valid=1 mid-window (o_t=4) and o_valid=1, i_ready=1 -> o_x_ready=0, o_t stays 4, o_valid stays 1 and o_sum unchanged. Resumes exactly on i_cg=1.
- i_rst_n=0 for 1 cycle at o_t=5 with o_valid=1 -> o_t=0, o_valid=0, o_sum=0. The following full window of i_y=3 gives o_sum=24.
